// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, blank and frame pulse registered; hs/vs one pixel later.
// Latency: DrawX/DrawY/blank/frame_start update on each pix_en edge; hs/vs lag the sync windows by one pix_en edge.
// Backpressure: none. pix_en=0 freezes every register. VGA_FRAME_COUNT_EN adds frame_cnt.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] hc, vc;
  logic [9:0] hc_nxt, vc_nxt;
  logic       hs_raw, vs_raw;
  logic       blank_nxt, fs_nxt;

  always_comb begin
    hc_nxt = hc;
    vc_nxt = vc;
    if (hc < H_MAX) begin
      hc_nxt = hc + 10'd1;
    end else begin
      hc_nxt = '0;
      vc_nxt = (vc == V_MAX) ? 10'd0 : vc + 10'd1;
    end
  end

  // Windows come from the current count so the registered syncs trail by one pixel.
  assign hs_raw    = (hc >= HS_START) && (hc <= HS_END);
  assign vs_raw    = (vc >= VS_START) && (vc <= VS_END);
  assign blank_nxt = (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
  assign fs_nxt    = (hc_nxt == 10'd0) && (vc_nxt == 10'd0);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc          <= H_MAX;
      vc          <= V_MAX;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      blank       <= blank_nxt;
      hs          <= ~hs_raw;
      vs          <= ~vs_raw;
      frame_start <= fs_nxt;
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

`ifdef VGA_FRAME_COUNT_EN
  // The frame entered straight out of reset is frame 0, so its start does not count.
  logic first_seen;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt  <= '0;
      first_seen <= 1'b0;
    end else if (pix_en && fs_nxt) begin
      if (first_seen) frame_cnt <= frame_cnt + 16'd1;
      first_seen <= 1'b1;
    end
  end
`endif

endmodule
